// File: rtl/exec_cc_unit_if.sv
// Execute-stage to M-register bundle: the E-stage/ALU inputs and control
// in one direction, and the CC, condition and M-register outputs in the other.
interface exec_cc_unit_if #(
    parameter int WIDTH = 64
);
    logic             e_valid;
    logic [3:0]       e_icode;
    logic [3:0]       e_ifun;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic [3:0]       e_dstE;
    logic             set_cc_allow;
    logic             m_stall;
    logic             m_bubble;

    logic [2:0]       cc;
    logic             e_cnd;
    logic [3:0]       e_dstE_out;
    logic             m_valid;
    logic [3:0]       m_icode;
    logic             m_cnd;
    logic [WIDTH-1:0] m_valE;
    logic [3:0]       m_dstE;

    modport master (
        output e_valid, e_icode, e_ifun, alu_result, alu_overflow, e_dstE,
               set_cc_allow, m_stall, m_bubble,
        input  cc, e_cnd, e_dstE_out, m_valid, m_icode, m_cnd, m_valE, m_dstE
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, alu_result, alu_overflow, e_dstE,
               set_cc_allow, m_stall, m_bubble,
        output cc, e_cnd, e_dstE_out, m_valid, m_icode, m_cnd, m_valE, m_dstE
    );
endinterface

// File: rtl/exec_cc_unit.sv
// Execute back end: flag derivation, CC register, jXX/cmov condition
// evaluation, cmov destination squash and the E->M pipeline register.
module exec_cc_unit #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] I_NOP = 4'h1
) (
    input  logic         clk,
    input  logic         reset,
    exec_cc_unit_if.slave bus
);
    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;

    logic [2:0]       r_cc;
    logic             r_m_valid;
    logic [3:0]       r_m_icode;
    logic             r_m_cnd;
    logic [WIDTH-1:0] r_m_vale;
    logic [3:0]       r_m_dste;

    logic             w_new_zf;
    logic             w_new_sf;
    logic             w_new_of;
    logic             w_cc_we;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;
    logic             w_cnd;
    logic [3:0]       w_dste_out;

    assign w_new_zf = (bus.alu_result == '0);
    assign w_new_sf = bus.alu_result[WIDTH-1];

    // Logical ops (andq/xorq) cannot overflow, so OF only follows the ALU on add/sub.
    always_comb begin
        w_new_of = 1'b0;
        if (bus.e_ifun == 4'd0 || bus.e_ifun == 4'd1) begin
            w_new_of = bus.alu_overflow;
        end
    end

    assign w_cc_we = bus.e_valid && (bus.e_icode == I_OPQ) && bus.set_cc_allow
                     && !bus.m_stall && !bus.m_bubble;

    assign {w_zf, w_sf, w_of} = r_cc;

    // Condition uses the registered flags, so an OPq followed directly by a
    // jXX/cmov sees the OPq result without any forwarding path.
    always_comb begin
        w_cnd = 1'b0;
        case (bus.e_ifun)
            4'd0: w_cnd = 1'b1;
            4'd1: w_cnd = (w_sf ^ w_of) | w_zf;
            4'd2: w_cnd = w_sf ^ w_of;
            4'd3: w_cnd = w_zf;
            4'd4: w_cnd = ~w_zf;
            4'd5: w_cnd = ~(w_sf ^ w_of);
            4'd6: w_cnd = ~(w_sf ^ w_of) & ~w_zf;
            default: w_cnd = 1'b0;
        endcase
        if (!bus.e_valid) begin
            w_cnd = 1'b0;
        end
    end

    always_comb begin
        w_dste_out = bus.e_dstE;
        if (bus.e_icode == I_CMOV && !w_cnd) begin
            w_dste_out = RNONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cc <= 3'b100;
        end else if (w_cc_we) begin
            r_cc <= {w_new_zf, w_new_sf, w_new_of};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.m_bubble) begin
            r_m_valid <= 1'b0;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_vale  <= '0;
            r_m_dste  <= RNONE;
        end else if (!bus.m_stall) begin
            r_m_valid <= bus.e_valid;
            r_m_icode <= bus.e_icode;
            r_m_cnd   <= w_cnd;
            r_m_vale  <= bus.alu_result;
            r_m_dste  <= w_dste_out;
        end
    end

    assign bus.cc         = r_cc;
    assign bus.e_cnd      = w_cnd;
    assign bus.e_dstE_out = w_dste_out;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_icode    = r_m_icode;
    assign bus.m_cnd      = r_m_cnd;
    assign bus.m_valE     = r_m_vale;
    assign bus.m_dstE     = r_m_dste;
endmodule

// File: tb/tb_exec_cc_unit.sv
// Vector-table bench for exec_cc_unit with a queue of expected M-register contents.
module tb_exec_cc_unit;
    localparam int WIDTH = 64;
    localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

    logic clk;
    logic reset;

    exec_cc_unit_if #(.WIDTH(WIDTH)) bus ();

    exec_cc_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] result;
        logic        ovf;
        logic [3:0]  dste;
        logic        allow;
        logic        stall;
        logic        bubble;
        logic        exp_cnd;
        logic [3:0]  exp_dste;
        logic [2:0]  exp_cc;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [3:0]  dste;
    } mrec_t;

    int total = 0;
    int bad   = 0;
    vec_t  vecs[20];
    mrec_t mq[$];
    mrec_t last_m;
    mrec_t bubble_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_m(input string tag);
        mrec_t e;
        if (mq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = mq.pop_front();
        check({tag, ".m_valid"}, 64'(bus.m_valid), 64'(e.valid));
        check({tag, ".m_icode"}, 64'(bus.m_icode), 64'(e.icode));
        check({tag, ".m_cnd"},   64'(bus.m_cnd),   64'(e.cnd));
        check({tag, ".m_valE"},  bus.m_valE,       e.vale);
        check({tag, ".m_dstE"},  64'(bus.m_dstE),  64'(e.dste));
    endtask

    task automatic drive(input vec_t v);
        bus.e_valid      = v.valid;
        bus.e_icode      = v.icode;
        bus.e_ifun       = v.ifun;
        bus.alu_result   = v.result;
        bus.alu_overflow = v.ovf;
        bus.e_dstE       = v.dste;
        bus.set_cc_allow = v.allow;
        bus.m_stall      = v.stall;
        bus.m_bubble     = v.bubble;
    endtask

    // Expected M contents follow the bubble > stall > load priority.
    task automatic push_m(input vec_t v);
        mrec_t e;
        if (v.bubble) e = bubble_m;
        else if (v.stall) e = last_m;
        else e = '{v.valid, v.icode, v.exp_cnd, v.result, v.exp_dste};
        last_m = e;
        mq.push_back(e);
    endtask

    function automatic vec_t mk(input logic valid, input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] result, input logic ovf, input logic [3:0] dste,
                                input logic allow, input logic stall, input logic bubble,
                                input logic exp_cnd, input logic [3:0] exp_dste, input logic [2:0] exp_cc);
        vec_t v;
        v = '{valid, icode, ifun, result, ovf, dste, allow, stall, bubble, exp_cnd, exp_dste, exp_cc};
        return v;
    endfunction

    initial begin
        bubble_m = '{1'b0, 4'h1, 1'b0, 64'd0, 4'hF};
        //          vld icd ifn result ovf dst alw stl bub | cnd dstE cc_after
        vecs[0]  = mk(0, 4'h0, 4'h0, 64'd0,  0, 4'hF, 1, 0, 0,  0, 4'hF, 3'b100);
        vecs[1]  = mk(1, 4'h6, 4'h1, 64'd0,  0, 4'h2, 1, 0, 0,  1, 4'h2, 3'b100);
        vecs[2]  = mk(1, 4'h7, 4'h3, 64'd0,  0, 4'hF, 1, 0, 0,  1, 4'hF, 3'b100);
        vecs[3]  = mk(1, 4'h6, 4'h0, MSB,    1, 4'h5, 1, 0, 0,  1, 4'h5, 3'b011);
        vecs[4]  = mk(1, 4'h2, 4'h2, 64'd0,  0, 4'h3, 1, 0, 0,  0, 4'hF, 3'b011);
        vecs[5]  = mk(1, 4'h2, 4'h5, 64'd0,  0, 4'h3, 1, 0, 0,  1, 4'h3, 3'b011);
        vecs[6]  = mk(1, 4'h6, 4'h3, 64'd5,  1, 4'h6, 1, 0, 0,  0, 4'h6, 3'b000);
        vecs[7]  = mk(1, 4'h6, 4'h0, 64'd0,  0, 4'h1, 0, 0, 0,  1, 4'h1, 3'b000);
        vecs[8]  = mk(1, 4'h6, 4'h0, 64'd0,  0, 4'h1, 1, 0, 1,  1, 4'h1, 3'b000);
        vecs[9]  = mk(1, 4'h7, 4'h4, 64'h77, 0, 4'hF, 1, 0, 0,  1, 4'hF, 3'b000);
        vecs[10] = mk(1, 4'h6, 4'h0, 64'd0,  0, 4'h2, 1, 1, 0,  1, 4'h2, 3'b000);
        vecs[11] = mk(1, 4'h6, 4'h1, 64'd0,  0, 4'h2, 1, 1, 0,  0, 4'h2, 3'b000);
        vecs[12] = mk(1, 4'h6, 4'h0, 64'd0,  0, 4'h2, 1, 1, 1,  1, 4'h2, 3'b000);
        vecs[13] = mk(1, 4'h7, 4'h9, 64'd0,  0, 4'hF, 1, 0, 0,  0, 4'hF, 3'b000);
        vecs[14] = mk(0, 4'h6, 4'h0, 64'd0,  0, 4'h4, 1, 0, 0,  0, 4'h4, 3'b000);
        vecs[15] = mk(1, 4'h6, 4'h2, MSB,    1, 4'h8, 1, 0, 0,  0, 4'h8, 3'b010);
        vecs[16] = mk(1, 4'h7, 4'h2, 64'd0,  0, 4'hF, 1, 0, 0,  1, 4'hF, 3'b010);
        vecs[17] = mk(1, 4'h7, 4'h6, 64'd0,  0, 4'hF, 1, 0, 0,  0, 4'hF, 3'b010);
        vecs[18] = mk(1, 4'h2, 4'h1, 64'h9,  0, 4'h7, 1, 0, 0,  1, 4'h7, 3'b010);
        vecs[19] = mk(1, 4'h2, 4'h3, 64'h9,  0, 4'h7, 1, 0, 0,  0, 4'hF, 3'b010);

        reset = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check("reset.cc", 64'(bus.cc), 64'(3'b100));
        mq.push_back(bubble_m);
        last_m = bubble_m;
        check_m("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            push_m(vecs[i]);
            #1;
            check($sformatf("v%0d.e_cnd", i), 64'(bus.e_cnd), 64'(vecs[i].exp_cnd));
            check($sformatf("v%0d.e_dstE_out", i), 64'(bus.e_dstE_out), 64'(vecs[i].exp_dste));
            @(posedge clk);
            #1;
            check($sformatf("v%0d.cc", i), 64'(bus.cc), 64'(vecs[i].exp_cc));
            check_m($sformatf("v%0d", i));
            $display("vec %0d icode=%0h ifun=%0h cnd=%0b cc=%03b m_dstE=%0h",
                     i, vecs[i].icode, vecs[i].ifun, bus.e_cnd, bus.cc, bus.m_dstE);
        end

        // Reset arriving while M is stalled must still clear everything.
        @(negedge clk);
        drive(mk(1, 4'h6, 4'h1, 64'd3, 0, 4'h9, 1, 0, 0, 1, 4'h9, 3'b000));
        @(posedge clk);
        #1;
        check("pre_stall.cc", 64'(bus.cc), 64'(3'b000));
        check("pre_stall.m_valE", bus.m_valE, 64'd3);
        @(negedge clk);
        bus.m_stall = 1'b1;
        @(posedge clk);
        #1;
        check("stall.m_valE", bus.m_valE, 64'd3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall.cc", 64'(bus.cc), 64'(3'b100));
        mq.push_back(bubble_m);
        check_m("rst_stall");
        $display("reset during stall: cc=%03b m_icode=%0h", bus.cc, bus.m_icode);

        if (mq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", mq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
